// File: rtl/soc_ctrl_pll_lock_mon_if.sv
// Register-side and status signals of one PLL lock monitor, grouped so the
// monitor and its consumer share a single bundle.
interface soc_ctrl_pll_lock_mon_if #(
  parameter int unsigned REF_DIV_BW  = 4,
  parameter int unsigned FB_DIV_BW   = 12,
  parameter int unsigned LOSS_CNT_BW = 8
);
  logic                   pll_locked_i;
  logic [REF_DIV_BW-1:0]  ref_div_i;
  logic [FB_DIV_BW-1:0]   fb_div_i;
  logic                   retry_i;
  logic                   clr_i;
  logic                   locked_o;
  logic                   timeout_o;
  logic                   lock_lost_o;
  logic [LOSS_CNT_BW-1:0] loss_cnt_o;
  logic [1:0]             state_o;

  // Driver side: the PLL/register block and whoever consumes the status.
  modport master (
    output pll_locked_i, ref_div_i, fb_div_i, retry_i, clr_i,
    input  locked_o, timeout_o, lock_lost_o, loss_cnt_o, state_o
  );

  // Monitor side.
  modport slave (
    input  pll_locked_i, ref_div_i, fb_div_i, retry_i, clr_i,
    output locked_o, timeout_o, lock_lost_o, loss_cnt_o, state_o
  );
endinterface

// File: rtl/soc_ctrl_pll_lock_mon.sv
// PLL lock qualifier: synchronises the raw lock flag, demands a run of
// continuous lock before reporting locked, records lock losses and flags a
// timeout when lock never arrives. Divider changes restart qualification.
module soc_ctrl_pll_lock_mon #(
  parameter int unsigned REF_DIV_BW    = 4,
  parameter int unsigned FB_DIV_BW     = 12,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned LOSS_CNT_BW   = 8
) (
  input logic                    clk_i,
  input logic                    arst_ni,
  soc_ctrl_pll_lock_mon_if.slave bus_io
);

  localparam int unsigned CntMax = (STABLE_CYCLES > LOCK_TIMEOUT) ? STABLE_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned DivW   = REF_DIV_BW + FB_DIV_BW;

  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StWaitLock = 2'b00,
    StSettle   = 2'b01,
    StLocked   = 2'b10,
    StTimeout  = 2'b11
  } state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DivW-1:0]        div_q;
  logic [DivW-1:0]        div_cur;
  logic                   lock_s;
  logic                   cfg_chg;
  logic                   loss_ev;
  logic                   lock_lost_q;
  logic [LOSS_CNT_BW-1:0] loss_cnt_q;

  assign lock_s  = sync_q[SYNC_STAGES-1];
  assign div_cur = {bus_io.ref_div_i, bus_io.fb_div_i};
  assign cfg_chg = (div_cur != div_q);
  // A divider change outranks a lock drop, so it is never counted as a loss.
  assign loss_ev = !cfg_chg && (state_q == StLocked) && !lock_s;

  // Synchroniser for the asynchronous raw lock flag.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus_io.pll_locked_i};
    end
  end

  // Previous divider setting, refreshed every cycle for change detection.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      div_q <= '0;
    end else begin
      div_q <= div_cur;
    end
  end

  // Qualification FSM with its shared wait/settle counter.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
    end else if (cfg_chg) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StWaitLock: begin
          if (lock_s) begin
            state_q <= StSettle;
            cnt_q   <= '0;
          end else if (cnt_q == TimeoutLast) begin
            state_q <= StTimeout;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSettle: begin
          if (!lock_s) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end else if (cnt_q == StableLast) begin
            state_q <= StLocked;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StLocked: begin
          if (!lock_s) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end
        end
        StTimeout: begin
          // Raw lock is ignored here; only software can restart the search.
          if (bus_io.retry_i) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= StWaitLock;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Sticky loss flag and saturating loss counter; a loss beats a same-cycle clear.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else if (loss_ev) begin
      lock_lost_q <= 1'b1;
      if (bus_io.clr_i) begin
        loss_cnt_q <= LOSS_CNT_BW'(1);
      end else if (loss_cnt_q != '1) begin
        loss_cnt_q <= loss_cnt_q + 1'b1;
      end
    end else if (bus_io.clr_i) begin
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
    end
  end

  assign bus_io.locked_o    = (state_q == StLocked);
  assign bus_io.timeout_o   = (state_q == StTimeout);
  assign bus_io.state_o     = state_q;
  assign bus_io.lock_lost_o = lock_lost_q;
  assign bus_io.loss_cnt_o  = loss_cnt_q;

endmodule
